// File: rtl/mixcolumns_engine.sv
// -----------------------------------------------------------------------------
// mixcolumns_engine
//
// Iterative AES MixColumns / InvMixColumns engine. A 128-bit state is accepted
// over a valid/ready handshake, COLS_PER_CYCLE columns are mixed in place per
// clock, and the result is offered on a valid/ready output. The direction
// (forward or inverse) is captured once per block at acceptance.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds valid and its data stable until that edge; the
// consumer may raise or lower ready freely. Data is only sampled on a transfer.
//
// Parameters:
//   COLS_PER_CYCLE  columns mixed per clock: 1, 2 or 4 (anything else fails
//                   elaboration). The block takes N = 4/COLS_PER_CYCLE cycles.
//   REG_OUT         1: result captured in a dedicated output register.
//                   0: out_data driven straight from the working register.
//
// Optional build macro:
//   MIXCOL_BYPASS_EN  adds input in_bypass, sampled at acceptance; when 1 the
//                     block goes directly to DONE with out_data = in_data.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data/in_inv (and in_bypass) are valid
//   in_ready   engine can accept a block this cycle
//   in_data    state; column c = [127-32c -: 32]; byte r = [31-8r -: 8]
//   in_inv     0 = MixColumns, 1 = InvMixColumns
//   in_bypass  (MIXCOL_BYPASS_EN only) pass the block through unmixed
//   out_valid  out_data holds a finished block
//   out_ready  downstream accepts out_data
//   out_data   mixed state, same byte ordering as in_data
//   busy       high while columns are being mixed
// -----------------------------------------------------------------------------
module mixcolumns_engine #(
   parameter int COLS_PER_CYCLE = 1,
   parameter int REG_OUT        = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
`ifdef MIXCOL_BYPASS_EN
   input  logic         in_bypass,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int N = 4 / COLS_PER_CYCLE;

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $fatal(1, "mixcolumns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // GF(2^8) helpers, reduction polynomial 0x11b, built from xtime and XOR only
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mul11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] mul13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mul14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   // Row r uses the coefficient row rotated right by r, so byte a[(r+k)%4]
   // always meets coefficient k of the base row.
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0] a [4];
      logic [7:0] b [4];
      for (int r = 0; r < 4; r++) begin
         a[r] = col[31-8*r -: 8];
      end
      for (int r = 0; r < 4; r++) begin
         if (inv) begin
            b[r] = mul14(a[r]) ^ mul11(a[(r+1)%4]) ^ mul13(a[(r+2)%4]) ^ mul9(a[(r+3)%4]);
         end else begin
            b[r] = xtime(a[r]) ^ mul3(a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
         end
      end
      return {b[0], b[1], b[2], b[3]};
   endfunction

   // ---------------------------------------------------------------------------
   // Signals
   // ---------------------------------------------------------------------------
   state_t         r_state;
   state_t         w_next_state;
   logic [127:0]   r_work;
   logic           r_mode;
   logic [1:0]     r_cnt;
   logic [127:0]   w_next_work;
   logic           w_in_ready;
   logic           w_accept;
   logic           w_last;
   logic           w_bypass;
   logic           w_load_out;
   logic [127:0]   w_out_src;

`ifdef MIXCOL_BYPASS_EN
   assign w_bypass = in_bypass;
`else
   assign w_bypass = 1'b0;
`endif

   // in_ready is forced low while reset is held, even though the state is IDLE.
   assign in_ready  = w_in_ready & rst_n;
   assign w_accept  = in_valid & in_ready;
   assign w_last    = (r_cnt == 2'(N - 1));
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_BUSY);

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = w_bypass ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (w_last) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            // Output and input handshakes may coincide: the new block goes
            // straight in without passing through IDLE.
            w_in_ready = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  w_next_state = w_bypass ? S_DONE : S_BUSY;
               end else begin
                  w_next_state = S_IDLE;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Column datapath: only the COLS_PER_CYCLE columns selected by r_cnt are
   // replaced; the rest of the working register passes through.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_work = r_work;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         w_next_work[127 - 32*(int'(r_cnt)*COLS_PER_CYCLE + k) -: 32] =
            mix_col(r_work[127 - 32*(int'(r_cnt)*COLS_PER_CYCLE + k) -: 32], r_mode);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work <= '0;
         r_mode <= 1'b0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_work <= in_data;
         r_mode <= in_inv;
         r_cnt  <= '0;
      end else if (r_state == S_BUSY) begin
         r_work <= w_next_work;
         r_cnt  <= r_cnt + 2'd1;
      end
   end

   // The output register is loaded on the same edge that enters DONE, so both
   // REG_OUT settings present the result with identical timing.
   assign w_load_out = (w_accept && w_bypass) || ((r_state == S_BUSY) && w_last);
   assign w_out_src  = w_accept ? in_data : w_next_work;

   if (REG_OUT != 0) begin : g_reg_out
      logic [127:0] r_out_data;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_out_data <= '0;
         end else if (w_load_out) begin
            r_out_data <= w_out_src;
         end
      end
      assign out_data = r_out_data;
   end else begin : g_no_reg_out
      // r_work only changes on acceptance or while BUSY, so it is stable in DONE.
      assign out_data = r_work;
   end

endmodule
